// File: rtl/out_commutator_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | out_commutator_ctrl_pkg                                              |
// | Shared block size, lane data width and controller state encoding.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package out_commutator_ctrl_pkg;

  localparam int LEN_DEFAULT = 64;
  localparam int CW_DEFAULT  = 6;
  localparam int NB          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_WR_RD = 2'd2,
    ST_RD    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/out_commutator_ctrl_blk_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blk_counter                                                          |
// | Block sample counter with load-to-zero, enable and terminal count.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module blk_counter #(
  parameter int CW  = 6,
  parameter int LEN = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load and enable together yield 1: the loading cycle itself counts as a sample.
  always_comb begin
    cnt_d = load_i ? '0 : cnt_q;
    if (en_i) cnt_d = cnt_d + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(LEN - 1));

endmodule
`default_nettype wire

// File: rtl/out_commutator_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | out_commutator_ctrl                                                  |
// | Sequences write/read windows of the four FFT output remap lanes.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module out_commutator_ctrl
  import out_commutator_ctrl_pkg::*;
#(
  parameter int LEN = LEN_DEFAULT,
  parameter int CW  = CW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        remap_start,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_gap,
  output logic        err_sop
);

  state_e        state_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          wr_tc, rd_tc;
  logic          sop_acc, writing, reading, gap, wr_done, rd_done;
  logic          wr_load, wr_en, rd_load, rd_en;
  logic          out_valid_q, out_sop_q, out_eop_q, err_gap_q, err_sop_q;
  logic [15:0]   frame_cnt_q;

  // wr_cnt holds the index of the sample presented this cycle while writing.
  always_comb begin
    sop_acc = in_valid & in_sop;
    writing = (state_q == ST_WR) || (state_q == ST_WR_RD);
    reading = (state_q == ST_RD) || (state_q == ST_WR_RD);
    gap     = writing & ~in_valid & (wr_cnt != '0);
    wr_done = writing & in_valid & ~in_sop & wr_tc;
    rd_done = reading & rd_tc;
    wr_load = sop_acc | gap;
    wr_en   = sop_acc | (writing & in_valid);
    rd_load = wr_done;
    rd_en   = reading & ~wr_done;
  end

  blk_counter #(.CW(CW), .LEN(LEN)) u_wr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (wr_load),
    .en_i    (wr_en),
    .cnt_o   (wr_cnt),
    .tc_o    (wr_tc)
  );

  blk_counter #(.CW(CW), .LEN(LEN)) u_rd_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (rd_load),
    .en_i    (rd_en),
    .cnt_o   (rd_cnt),
    .tc_o    (rd_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_gap_q   <= 1'b0;
      err_sop_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (sop_acc) state_q <= ST_WR;
        ST_WR: begin
          if (sop_acc)      state_q <= ST_WR;
          else if (gap)     state_q <= ST_IDLE;
          else if (wr_done) state_q <= ST_RD;
        end
        ST_RD: begin
          if (sop_acc)    state_q <= rd_tc ? ST_WR : ST_WR_RD;
          else if (rd_tc) state_q <= ST_IDLE;
        end
        ST_WR_RD: begin
          // A block written here began after the read started, so it cannot finish first.
          if (sop_acc)      state_q <= rd_tc ? ST_WR : ST_WR_RD;
          else if (gap)     state_q <= rd_tc ? ST_IDLE : ST_RD;
          else if (wr_done) state_q <= ST_RD;
          else if (rd_tc)   state_q <= ST_WR;
        end
        default: state_q <= ST_IDLE;
      endcase
      out_valid_q <= reading;
      out_sop_q   <= reading && (rd_cnt == '0);
      out_eop_q   <= rd_done;
      err_gap_q   <= gap;
      err_sop_q   <= writing & sop_acc;
      if (rd_done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign remap_start = reset_n & sop_acc;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign err_gap     = err_gap_q;
  assign err_sop     = err_sop_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/out_commutator_ctrl.md
OUT_COMMUTATOR_CTRL -- requirements
Module: out_commutator_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 64: samples per lane per block, equal to FFT points / 4; power of two, 4..1024.
REQ-002 SHALL have parameter CW, default 6: counter width, equal to log2(LEN).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  lane data from the last FFT stage valid this cycle.
REQ-006 in_sop  input  1  first sample of a block; qualified by in_valid.
REQ-007 remap_start  output  1  one-cycle pulse to the four lane remap instances, coincident with the block's first sample.
REQ-008 out_valid  output  1  remapped output data valid.
REQ-009 out_sop / out_eop  output  1 each  first / last output sample of a block.
REQ-010 busy  output  1  any write or read in progress.
REQ-011 frame_cnt  output  16  completed output blocks, wraps 0xFFFF->0.
REQ-012 err_gap / err_sop  output  1 each  single-cycle error pulses.

Function
REQ-013 Remap contract: a sample written at cycle t0+j (j=0..LEN-1) SHALL be output at cycle t0+LEN+j; the read window is fixed by t0 alone.
REQ-014 States SHALL be IDLE, WR, WR_RD, RD.
REQ-015 Write counter wr_cnt SHALL load 0 on an accepted in_sop, increment on each in_valid while writing, and end the write at LEN-1.
REQ-016 Read counter rd_cnt SHALL start at 0 exactly LEN cycles after the block's remap_start, increment every cycle, and end at LEN-1.
REQ-017 remap_start SHALL equal in_valid&in_sop, combinational from registered state, when the state is IDLE, RD, or WR/WR_RD at wr_cnt==LEN-1.
REQ-018 Transitions:
 - IDLE->WR on in_sop.
 - WR->WR_RD when the write completes and the next in_sop arrives back-to-back.
 - WR->RD when the write completes with no new in_sop.
 - RD->WR_RD on in_sop.
 - RD->IDLE at rd_cnt==LEN-1 with no in_sop.
 - WR_RD->WR when the read ends while writing continues.
 - WR_RD->RD when the write ends with no new sop.
REQ-019 out_valid SHALL be high exactly during read windows; out_sop at rd_cnt==0; out_eop at rd_cnt==LEN-1; all registered, one cycle after the internal window start.
REQ-020 frame_cnt SHALL increment on each out_eop.
REQ-021 in_valid low mid-write (wr_cnt 1..LEN-1) SHALL pulse err_gap and abandon the block: no read window is scheduled for it; any pending read of the prior block continues.
REQ-022 in_sop mid-write SHALL pulse err_sop, abandon the current block, and restart the write at wr_cnt=0 with a new remap_start.
REQ-023 Simultaneous read end and new in_sop SHALL service both with no bubble.
REQ-024 in_valid without in_sop in IDLE/RD SHALL be ignored and raise no error.
REQ-025 busy SHALL be high in every state except IDLE.

Reset
REQ-026 reset_n low SHALL force: state IDLE, counters 0, frame_cnt 0, all outputs 0, including mid-block; no outputs SHALL follow for the abandoned data.
REQ-027 Reset deassertion SHALL take effect on the first clk edge with reset_n high; the block SHALL accept in_sop on that same edge.

Structure
REQ-028 LEN default and state encodings SHALL live in the shared parameter include, next to the data width nb.
REQ-029 A sub-module blk_counter (CW-bit, load/enable/terminal-count) SHALL implement both wr_cnt and rd_cnt.
REQ-030 The block SHALL carry no datapath; it drives the start of the four remap lanes and qualifies their nb*4-bit output.

Verification (LEN=64)
REQ-031 Single block, sop at cycle 10, 64 valid cycles -> remap_start at 10; out_valid cycles 75..138 (registered); out_sop 75; out_eop 138; frame_cnt=1; state IDLE at 139.
REQ-032 Three back-to-back blocks -> continuous out_valid for 192 cycles; remap_start at 0, 64, 128; frame_cnt=3; no errors.
REQ-033 in_valid dropped at wr_cnt=20 -> err_gap one cycle; no out_valid for that block; frame_cnt unchanged.
REQ-034 in_sop at wr_cnt=30 -> err_sop; second remap_start; exactly one 64-cycle output window, keyed to the second sop.
REQ-035 reset_n low for 3 cycles during WR_RD -> all outputs 0 immediately, asynchronously; after release, no out_valid until a new sop+64.
REQ-036 Block gap of 5 cycles -> RD then WR_RD; output windows separated by a 5-cycle out_valid gap.
